// File: rtl/vga_pkg.sv
// Shared VGA timing, text-grid geometry and colour helpers for the text-mode scanner.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CHAR_W = 9;
  localparam int CHAR_H = 16;
  localparam int COLS   = 70;
  localparam int ROWS   = 30;

  localparam logic [7:0] CURSOR_CODE = 8'hFF;

  // Everything the second pipeline stage needs about one pixel, captured together.
  typedef struct packed {
    logic [7:0] data;
    logic [2:0] color;
    logic [3:0] px;
    logic       in_text;
    logic       active;
    logic       hs_pulse;
    logic       vs_pulse;
  } stage1_t;

  // Code 0 means plain white; any other code lights the R/G/B channels per bit.
  function automatic logic [11:0] color_map(input logic [2:0] code);
    logic [11:0] rgb;
    if (code == 3'b000) rgb = 12'hFFF;
    else                rgb = {{4{code[2]}}, {4{code[1]}}, {4{code[0]}}};
    return rgb;
  endfunction

endpackage

// File: rtl/vga_text_scanner_font_rom.sv
// 4096x9 glyph ROM addressed by {ascii, glyph line}; registered output, MSB is the leftmost pixel.
module font_rom (
  input  logic        clk,
  input  logic [11:0] addr,
  output logic [8:0]  row
);

  // Glyph table: 'A', a checkerboard test glyph at code 8'h01, everything else blank.
  function automatic logic [8:0] glyph(input logic [11:0] a);
    logic [8:0] g;
    g = 9'h000;
    case (a[11:4])
      8'h41: begin
        case (a[3:0])
          4'd0:    g = 9'b000010000;
          4'd1:    g = 9'b000101000;
          4'd2:    g = 9'b001000100;
          4'd3:    g = 9'b010000010;
          4'd4:    g = 9'b010000010;
          4'd5:    g = 9'b011111110;
          4'd6:    g = 9'b010000010;
          4'd7:    g = 9'b010000010;
          4'd8:    g = 9'b010000010;
          default: g = 9'h000;
        endcase
      end
      8'h01:   g = a[0] ? 9'h155 : 9'h0AA;
      default: g = 9'h000;
    endcase
    return g;
  endfunction

  always_ff @(posedge clk) begin
    row <= glyph(addr);
  end

endmodule

// File: rtl/vga_text_scanner.sv
// 640x480@60 text-mode scanner: walks the 70x30 text buffer and renders 9x16 glyphs with a 2-cycle pipeline.
module vga_text_scanner
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int CHAR_W   = vga_pkg::CHAR_W,
  parameter int CHAR_H   = vga_pkg::CHAR_H,
  parameter int COLS     = vga_pkg::COLS,
  parameter int ROWS     = vga_pkg::ROWS
) (
  input  logic       clk,
  input  logic       clrn,
  output logic [6:0] read_x,
  output logic [4:0] read_y,
  input  logic [7:0] data,
  input  logic [2:0] color,
  output logic       hsync,
  output logic       vsync,
  output logic       valid,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] TEXT_W   = 10'(COLS * CHAR_W);
  localparam logic [3:0] PX_LAST  = 4'(CHAR_W - 1);
  localparam logic [3:0] LN_LAST  = 4'(CHAR_H - 1);
  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [3:0] px_in_char;
  logic [6:0] char_col;
  logic [3:0] ln_in_char;
  logic [5:0] char_row;

  stage1_t    s1_next;
  stage1_t    s1;
  logic [8:0] glyph_q;
  logic [3:0] bit_idx;
  logic       lit;
  logic [11:0] pix_next;
  logic [11:0] rgb_q;

  // Cell position is tracked incrementally alongside the beam so no divider is needed.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      px_in_char <= '0;
      char_col   <= '0;
      ln_in_char <= '0;
      char_row   <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt      <= '0;
      px_in_char <= '0;
      char_col   <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt      <= '0;
        ln_in_char <= '0;
        char_row   <= '0;
      end else begin
        v_cnt <= v_cnt + 10'd1;
        if (ln_in_char == LN_LAST) begin
          ln_in_char <= '0;
          char_row   <= char_row + 6'd1;
        end else begin
          ln_in_char <= ln_in_char + 4'd1;
        end
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
      if (px_in_char == PX_LAST) begin
        px_in_char <= '0;
        char_col   <= char_col + 7'd1;
      end else begin
        px_in_char <= px_in_char + 4'd1;
      end
    end
  end

  // Past the text area the cell counters keep running; the fetch address holds the last cell instead.
  assign read_x = (char_col > COL_LAST) ? COL_LAST : char_col;
  assign read_y = (char_row > ROW_LAST) ? ROW_LAST[4:0] : char_row[4:0];

  always_comb begin
    s1_next          = '0;
    s1_next.data     = data;
    s1_next.color    = color;
    s1_next.px       = px_in_char;
    s1_next.in_text  = (h_cnt < TEXT_W) && (v_cnt < V_ACT);
    s1_next.active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    s1_next.hs_pulse = (h_cnt >= HS_START) && (h_cnt < HS_END);
    s1_next.vs_pulse = (v_cnt >= VS_START) && (v_cnt < VS_END);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) s1 <= '0;
    else       s1 <= s1_next;
  end

  // The ROM is addressed with the live fetch so its row lines up with stage 1.
  font_rom u_font_rom (
    .clk  (clk),
    .addr ({data, ln_in_char}),
    .row  (glyph_q)
  );

  always_comb begin
    bit_idx  = PX_LAST - s1.px;
    lit      = (s1.data == CURSOR_CODE) || glyph_q[bit_idx];
    pix_next = 12'h000;
    if (s1.active && s1.in_text && lit) pix_next = color_map(s1.color);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      valid <= 1'b0;
      rgb_q <= 12'h000;
    end else begin
      hsync <= ~s1.hs_pulse;
      vsync <= ~s1.vs_pulse;
      valid <= s1.active;
      rgb_q <= pix_next;
    end
  end

  assign vga_r = rgb_q[11:8];
  assign vga_g = rgb_q[7:4];
  assign vga_b = rgb_q[3:0];

endmodule

// File: tb/tb_vga_text_scanner.sv
// Bench for vga_text_scanner: arithmetic reference model over a random text buffer, a spot-check table and reset sequences.
module tb_vga_text_scanner;

  localparam int HT     = 800;
  localparam int HA     = 640;
  localparam int HS0    = 656;
  localparam int HSW    = 96;
  localparam int VA     = 48;
  localparam int VFP    = 3;
  localparam int VSW    = 2;
  localparam int VBP    = 4;
  localparam int VT     = VA + VFP + VSW + VBP;
  localparam int ROWS_T = 3;
  localparam int COLS_T = 70;

  typedef struct {
    int          h;
    int          v;
    logic        hs;
    logic        vs;
    logic        vld;
    logic [11:0] rgb;
  } vec_t;

  logic       clk;
  logic       clrn;
  logic [6:0] read_x;
  logic [4:0] read_y;
  logic [7:0] data;
  logic [2:0] color;
  logic       hsync;
  logic       vsync;
  logic       valid;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;

  logic [7:0] mem_data  [ROWS_T][COLS_T];
  logic [2:0] mem_color [ROWS_T][COLS_T];
  logic [8:0] glyph_a   [16];
  vec_t       vecs[$];

  int checks   = 0;
  int failures = 0;
  int hs_first = -1;
  int hs_low   = 0;
  int vs_first = -1;
  int vs_low   = 0;
  logic [2:0] valid_hist;

  vga_text_scanner #(
    .V_ACTIVE (VA),
    .V_FP     (VFP),
    .V_SYNC   (VSW),
    .V_BP     (VBP),
    .ROWS     (ROWS_T)
  ) dut (
    .clk    (clk),
    .clrn   (clrn),
    .read_x (read_x),
    .read_y (read_y),
    .data   (data),
    .color  (color),
    .hsync  (hsync),
    .vsync  (vsync),
    .valid  (valid),
    .vga_r  (vga_r),
    .vga_g  (vga_g),
    .vga_b  (vga_b)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Text memory: combinational answer for the requested cell.
  always_comb begin
    data  = 8'h00;
    color = 3'b000;
    if (int'(read_y) < ROWS_T && int'(read_x) < COLS_T) begin
      data  = mem_data[int'(read_y)][int'(read_x)];
      color = mem_color[int'(read_y)][int'(read_x)];
    end
  end

  function automatic logic [8:0] model_glyph(input logic [7:0] code, input int ln);
    if (code == 8'h41) return glyph_a[ln];
    if (code == 8'h01) return (ln % 2 == 1) ? 9'b101010101 : 9'b010101010;
    return 9'h000;
  endfunction

  function automatic logic [11:0] model_cmap(input logic [2:0] c);
    logic [3:0] r, g, b;
    if (c == 3'b000) return 12'hFFF;
    r = c[2] ? 4'hF : 4'h0;
    g = c[1] ? 4'hF : 4'h0;
    b = c[0] ? 4'hF : 4'h0;
    return {r, g, b};
  endfunction

  function automatic logic [11:0] model_pixel(input int h, input int v);
    logic [7:0] code;
    logic [8:0] g;
    int         bi;
    code = mem_data[v / 16][h / 9];
    g    = model_glyph(code, v % 16);
    bi   = 8 - (h % 9);
    if (code == 8'hFF || g[bi]) return model_cmap(mem_color[v / 16][h / 9]);
    return 12'h000;
  endfunction

  // Expected {hsync, vsync, valid, rgb, read_x, read_y} in cycle n after reset release.
  function automatic logic [31:0] model_out(input int n);
    int h0, v0, rx, ry, t, h, v;
    logic hs, vs, vld;
    logic [11:0] rgb;
    h0 = n % HT;
    v0 = (n / HT) % VT;
    rx = (h0 / 9 > COLS_T - 1) ? COLS_T - 1 : h0 / 9;
    ry = (v0 / 16 > ROWS_T - 1) ? ROWS_T - 1 : v0 / 16;
    hs = 1'b1; vs = 1'b1; vld = 1'b0; rgb = 12'h000;
    if (n >= 2) begin
      t   = n - 2;
      h   = t % HT;
      v   = (t / HT) % VT;
      vld = (h < HA) && (v < VA);
      hs  = !(h >= HS0 && h < HS0 + HSW);
      vs  = !(v >= VA + VFP && v < VA + VFP + VSW);
      if (vld && h < COLS_T * 9) rgb = model_pixel(h, v);
    end
    return {5'b0, hs, vs, vld, rgb, 7'(rx), 5'(ry)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic applyStimulus();
    int pick;
    for (int r = 0; r < ROWS_T; r++) begin
      for (int c = 0; c < COLS_T; c++) begin
        pick = int'($urandom_range(0, 4));
        case (pick)
          0:       mem_data[r][c] = 8'h00;
          1:       mem_data[r][c] = 8'h41;
          2:       mem_data[r][c] = 8'h01;
          3:       mem_data[r][c] = 8'hFF;
          default: mem_data[r][c] = 8'($urandom);
        endcase
        mem_color[r][c] = 3'($urandom);
      end
    end
    mem_data[0][0]                   = 8'h41;
    mem_color[0][0]                  = 3'b100;
    mem_data[ROWS_T-1][COLS_T-1]     = 8'hFF;
    mem_color[ROWS_T-1][COLS_T-1]    = 3'b000;
  endtask

  task automatic add_vec(input int h, input int v, input logic hs, input logic vs,
                         input logic vld, input logic [11:0] rgb);
    vec_t e;
    e.h = h; e.v = v; e.hs = hs; e.vs = vs; e.vld = vld; e.rgb = rgb;
    vecs.push_back(e);
  endtask

  function automatic logic [31:0] dut_out();
    return {5'b0, hsync, vsync, valid, vga_r, vga_g, vga_b, read_x, read_y};
  endfunction

  // Checks cycles 0..n_last after a reset release; the first run also gathers sync statistics and table hits.
  task automatic run_scan(input int n_last, input bit first_run);
    int h, v;
    for (int n = 0; n <= n_last; n++) begin
      checkOutput($sformatf("scan n=%0d", n), dut_out(), model_out(n));
      if (first_run) begin
        if (n < 3) valid_hist[2-n] = valid;
        if (n >= 2 && n < 2 + HT && !hsync) begin
          if (hs_first < 0) hs_first = n;
          hs_low++;
        end
        if (n >= 2 && n < 2 + HT * VT && !vsync) begin
          if (vs_first < 0) vs_first = n;
          vs_low++;
        end
        if (n >= 2 && n - 2 < HT * VT) begin
          h = (n - 2) % HT;
          v = (n - 2) / HT;
          foreach (vecs[i]) begin
            if (vecs[i].h == h && vecs[i].v == v)
              checkOutput($sformatf("vec h=%0d v=%0d", h, v),
                          {16'b0, hsync, vsync, valid, vga_r, vga_g, vga_b},
                          {16'b0, vecs[i].hs, vecs[i].vs, vecs[i].vld, vecs[i].rgb});
          end
        end
      end
      if (failures > 40) break;
      if (n < n_last) begin
        @(negedge clk);
        #1;
      end
    end
  endtask

  initial begin
    glyph_a[0]  = 9'b000010000; glyph_a[1]  = 9'b000101000;
    glyph_a[2]  = 9'b001000100; glyph_a[3]  = 9'b010000010;
    glyph_a[4]  = 9'b010000010; glyph_a[5]  = 9'b011111110;
    glyph_a[6]  = 9'b010000010; glyph_a[7]  = 9'b010000010;
    glyph_a[8]  = 9'b010000010;
    for (int i = 9; i < 16; i++) glyph_a[i] = 9'h000;

    for (int x = 0; x < 9; x++) add_vec(x, 0, 1'b1, 1'b1, 1'b1, (x == 4) ? 12'hF00 : 12'h000);
    add_vec(621, VA - 16, 1'b1, 1'b1, 1'b1, 12'hFFF);
    add_vec(625, VA - 16, 1'b1, 1'b1, 1'b1, 12'hFFF);
    add_vec(629, VA - 16, 1'b1, 1'b1, 1'b1, 12'hFFF);
    add_vec(621, VA - 1,  1'b1, 1'b1, 1'b1, 12'hFFF);
    add_vec(629, VA - 1,  1'b1, 1'b1, 1'b1, 12'hFFF);
    add_vec(630, VA - 1,  1'b1, 1'b1, 1'b1, 12'h000);
    add_vec(635, VA - 16, 1'b1, 1'b1, 1'b1, 12'h000);
    add_vec(639, VA - 1,  1'b1, 1'b1, 1'b1, 12'h000);
    add_vec(640, 0,       1'b1, 1'b1, 1'b0, 12'h000);
    add_vec(655, 0,       1'b1, 1'b1, 1'b0, 12'h000);
    add_vec(656, 0,       1'b0, 1'b1, 1'b0, 12'h000);
    add_vec(751, 0,       1'b0, 1'b1, 1'b0, 12'h000);
    add_vec(752, 0,       1'b1, 1'b1, 1'b0, 12'h000);
    add_vec(0, VA + VFP,  1'b1, 1'b0, 1'b0, 12'h000);
    add_vec(0, VA + VFP + VSW, 1'b1, 1'b1, 1'b0, 12'h000);

    applyStimulus();

    clrn = 1'b1;
    #5 clrn = 1'b0;
    @(negedge clk); #1;
    checkOutput("reset_hold_0", dut_out(), {5'b0, 3'b110, 12'h000, 7'd0, 5'd0});
    @(negedge clk); #1;
    checkOutput("reset_hold_1", dut_out(), {5'b0, 3'b110, 12'h000, 7'd0, 5'd0});

    @(negedge clk);
    clrn = 1'b1;
    #1;
    run_scan(HT * VT + 2 * HT + 2, 1'b1);

    checkOutput("valid_rise", {29'b0, valid_hist}, {29'b0, 3'b001});
    checkOutput("hsync_start", 32'(hs_first), 32'(HS0 + 2));
    checkOutput("hsync_width", 32'(hs_low), 32'(HSW));
    checkOutput("vsync_start", 32'(vs_first), 32'(2 + HT * (VA + VFP)));
    checkOutput("vsync_width", 32'(vs_low), 32'(VSW * HT));

    // Mid-frame reset at counter time h=300, v=10.
    @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    #1;
    run_scan(10 * HT + 300, 1'b0);
    clrn = 1'b0;
    #1;
    checkOutput("midreset_now", dut_out(), {5'b0, 3'b110, 12'h000, 7'd0, 5'd0});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checkOutput($sformatf("midreset_hold%0d", k), dut_out(), {5'b0, 3'b110, 12'h000, 7'd0, 5'd0});
    end
    @(negedge clk);
    clrn = 1'b1;
    #1;
    run_scan(3 * HT, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
